// File: rtl/cv32e41s_tcm_arbiter.sv
// Round-robin front end that shares one TCM port between two OBI masters.
// Optional conflict statistics counter: define CV32E41S_TCM_ARB_STATS_EN.
module cv32e41s_tcm_arbiter #(
  parameter logic [31:0] TCM_BASE = 32'h0010_0000,
  parameter int unsigned MEM_SIZE = 4096,
  parameter int unsigned A_WID    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef CV32E41S_TCM_ARB_STATS_EN
  input  logic             conflict_clr_i,
  output logic [15:0]      conflict_cnt_o,
`endif
  input  logic             m0_req_i,
  output logic             m0_gnt_o,
  input  logic [31:0]      m0_addr_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_be_i,
  input  logic [31:0]      m0_wdata_i,
  output logic             m0_rvalid_o,
  output logic [31:0]      m0_rdata_o,
  output logic             m0_err_o,
  input  logic             m1_req_i,
  output logic             m1_gnt_o,
  input  logic [31:0]      m1_addr_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_be_i,
  input  logic [31:0]      m1_wdata_i,
  output logic             m1_rvalid_o,
  output logic [31:0]      m1_rdata_o,
  output logic             m1_err_o,
  output logic             tcm_req_o,
  output logic             tcm_we_o,
  output logic [3:0]       tcm_be_o,
  output logic [A_WID-1:0] tcm_addr_o,
  output logic [31:0]      tcm_wdata_o,
  input  logic             tcm_rvalid_i,
  input  logic [31:0]      tcm_rdata_i
);

  logic        last_q;
  logic        resp_v_q;
  logic        resp_own_q;
  logic        resp_err_q;

  logic [31:0] m0_off;
  logic [31:0] m1_off;
  logic        m0_hit;
  logic        m1_hit;
  logic        gnt0;
  logic        gnt1;
  logic        granted;
  logic        sel_hit;
  logic [31:0] sel_off;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  // Unsigned subtraction makes addresses below the base wrap to a miss.
  assign m0_off = m0_addr_i - TCM_BASE;
  assign m1_off = m1_addr_i - TCM_BASE;
  assign m0_hit = m0_off < 32'(MEM_SIZE);
  assign m1_hit = m1_off < 32'(MEM_SIZE);

  // On conflict the master that did not win last time is granted.
  assign gnt0    = m0_req_i & (~m1_req_i | last_q);
  assign gnt1    = m1_req_i & (~m0_req_i | ~last_q);
  assign granted = gnt0 | gnt1;
  assign sel_hit = gnt1 ? m1_hit : m0_hit;
  assign sel_off = gnt1 ? m1_off : m0_off;

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    tcm_req_o   = 1'b0;
    tcm_we_o    = 1'b0;
    tcm_be_o    = 4'h0;
    tcm_addr_o  = '0;
    tcm_wdata_o = 32'h0;
    if (granted && sel_hit) begin
      tcm_req_o   = 1'b1;
      tcm_addr_o  = A_WID'(sel_off);
      tcm_we_o    = gnt1 ? m1_we_i    : m0_we_i;
      tcm_be_o    = gnt1 ? m1_be_i    : m0_be_i;
      tcm_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      resp_v_q   <= 1'b0;
      resp_own_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if (granted) begin
        last_q <= gnt1;
      end
      resp_v_q   <= granted;
      resp_own_q <= gnt1;
      resp_err_q <= granted & ~sel_hit;
    end
  end

  // Misses answer locally; hits forward the TCM's fixed-latency response.
  assign rsp_valid = resp_v_q & (resp_err_q | tcm_rvalid_i);
  assign rsp_data  = (resp_v_q & ~resp_err_q) ? tcm_rdata_i : 32'h0;

  assign m0_rvalid_o = rsp_valid & ~resp_own_q;
  assign m1_rvalid_o = rsp_valid &  resp_own_q;
  assign m0_rdata_o  = resp_own_q ? 32'h0 : rsp_data;
  assign m1_rdata_o  = resp_own_q ? rsp_data : 32'h0;
  assign m0_err_o    = resp_v_q & resp_err_q & ~resp_own_q;
  assign m1_err_o    = resp_v_q & resp_err_q &  resp_own_q;

`ifdef CV32E41S_TCM_ARB_STATS_EN
  // Saturating count of cycles with both masters requesting; clear has priority.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= 16'h0;
    end else if (conflict_clr_i) begin
      conflict_cnt_o <= 16'h0;
    end else if (m0_req_i && m1_req_i && (conflict_cnt_o != 16'hFFFF)) begin
      conflict_cnt_o <= conflict_cnt_o + 16'd1;
    end
  end
`endif

  a_tcm_resp: assert property (@(posedge clk_i) disable iff (rst_i)
    (resp_v_q && !resp_err_q) |-> tcm_rvalid_i);
  a_one_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0({m0_rvalid_o, m1_rvalid_o}));

endmodule
